// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared types for the RV32 instruction encoder:
//   - OpCode, RTypeFunct3, ITypeFunct3 : field encodings the encoder knows
//   - r_type_t, i_type_t, instruction_t: bit layouts of the 32-bit word
//   - state_t                          : encoder FSM states
//   - NOP                              : word substituted for illegal requests
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

    // Only register-register ALU ops and register-immediate ALU ops exist here.
    typedef enum logic [6:0] {
        R_TYPE = 7'b0110011,
        I_TYPE = 7'b0010011
    } OpCode;

    typedef enum logic [2:0] {
        ADD_OR_SUB = 3'd0,
        SLL        = 3'd1,
        SLT        = 3'd2,
        SLTU       = 3'd3,
        XOR        = 3'd4,
        SRL_OR_SRA = 3'd5,
        OR         = 3'd6,
        AND        = 3'd7
    } RTypeFunct3;

    typedef enum logic [2:0] {
        ADDI         = 3'd0,
        SLLI         = 3'd1,
        SLTI         = 3'd2,
        SLTIU        = 3'd3,
        XORI         = 3'd4,
        SRLI_OR_SRAI = 3'd5,
        ORI          = 3'd6,
        ANDI         = 3'd7
    } ITypeFunct3;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_type_t;

    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } i_type_t;

    // All views are 32 bits wide, so the same storage can be filled through
    // whichever layout matches the opcode and read back as a raw word.
    typedef union packed {
        r_type_t     r;
        i_type_t     i;
        logic [31:0] raw;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h00000013;

    // funct7 values: base operation and the "alternate" (SUB / SRA / SRAI).
    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    // R-type: alternate funct7 only exists for SUB and SRA.
    function automatic logic r_type_legal(input logic [6:0] funct7,
                                          input logic [2:0] funct3);
        logic ok;
        ok = (funct7 == FUNCT7_BASE) ||
             ((funct7 == FUNCT7_ALT) &&
              ((funct3 == ADD_OR_SUB) || (funct3 == SRL_OR_SRA)));
        return ok;
    endfunction

    // I-type: only the shift immediates constrain imm[11:5]; SRAI is the
    // single case where the alternate pattern is allowed.
    function automatic logic i_type_legal(input logic [11:0] imm,
                                          input logic [2:0]  funct3);
        logic ok;
        ok = 1'b1;
        if (funct3 == SLLI) begin
            ok = (imm[11:5] == FUNCT7_BASE);
        end else if (funct3 == SRLI_OR_SRAI) begin
            ok = (imm[11:5] == FUNCT7_BASE) || (imm[11:5] == FUNCT7_ALT);
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Combinational field packer: turns one field request into a 32-bit RV32
// instruction word and flags requests that are not legal encodings.
// Illegal requests produce NOP on word so the caller can write it as-is.
//
// Ports
//   opcode, funct3, funct7, rd, rs1, rs2, imm : request fields
//   word    : encoded instruction (NOP when illegal)
//   illegal : request had a bad opcode or a disallowed funct7 / imm[11:5]
// -----------------------------------------------------------------------------
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    instruction_t enc;

    always_comb begin
        enc     = '0;
        illegal = 1'b0;
        case (opcode)
            R_TYPE: begin
                enc.r.funct7 = funct7;
                enc.r.rs2    = rs2;
                enc.r.rs1    = rs1;
                enc.r.funct3 = funct3;
                enc.r.rd     = rd;
                enc.r.opcode = opcode;
                illegal      = !r_type_legal(funct7, funct3);
            end
            I_TYPE: begin
                // For shifts imm[4:0] is shamt and imm[11:5] sits where
                // funct7 would be, so the plain I layout already covers them.
                enc.i.imm    = imm;
                enc.i.rs1    = rs1;
                enc.i.funct3 = funct3;
                enc.i.rd     = rd;
                enc.i.opcode = opcode;
                illegal      = !i_type_legal(imm, funct3);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign word = illegal ? NOP : enc.raw;

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Accepts a stream of instruction field requests, encodes each into a 32-bit
// RV32 word and writes it to consecutive word addresses of an instruction
// memory, starting at base_addr. One output register stage sits between the
// request handshake and the memory write port.
//
// Ports
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, base_addr      : begin a load (IDLE only); base_addr[1:0] ignored
//   req_valid / req_ready : field-request handshake
//   req_opcode .. req_imm : instruction fields
//   req_last              : final request of the program
//   mem_we / mem_ready    : memory write handshake
//   mem_addr, mem_wdata   : write address and encoded word
//   busy                  : load in progress (RUN, DRAIN)
//   done                  : one-cycle pulse when the load has finished
//   err                   : sticky illegal-request flag, cleared on start
//   count                 : words written since start, saturating
// -----------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [15:0] MAX_COUNT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_opcode,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [11:0] req_imm,
    input  logic        req_last,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] count
);

    state_t      state_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;
    logic [15:0] count_reg;

    logic [31:0] packed_word;
    logic        packed_illegal;
    logic        accept;
    logic        write_done;

    instr_pack u_pack (
        .opcode  (req_opcode),
        .funct3  (req_funct3),
        .funct7  (req_funct7),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .imm     (req_imm),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    // The output stage can take a new word when it is empty or is being
    // emptied this very cycle, which gives one word per cycle with no bubble.
    assign req_ready  = (state_reg == RUN) && (!mem_we_reg || mem_ready);
    assign accept     = req_valid && req_ready;
    assign write_done = mem_we_reg && mem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'h0;
            mem_wdata_reg <= 32'h0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            count_reg     <= 16'h0;
        end else begin
            // mem_addr is the address of the word currently (or next)
            // presented, so it advances only when a write completes.
            if (write_done) begin
                mem_addr_reg <= mem_addr_reg + 32'd4;
                if (count_reg < MAX_COUNT) begin
                    count_reg <= count_reg + 16'd1;
                end
            end

            // A new acceptance reloads the stage even if the old word is
            // completing in the same cycle.
            if (accept) begin
                mem_we_reg    <= 1'b1;
                mem_wdata_reg <= packed_word;
                if (packed_illegal) begin
                    err_reg <= 1'b1;
                end
            end else if (write_done) begin
                mem_we_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= RUN;
                        busy_reg     <= 1'b1;
                        mem_addr_reg <= {base_addr[31:2], 2'b00};
                        count_reg    <= 16'h0;
                        err_reg      <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept && req_last) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The stage always holds the last word on entry; the
                    // empty-stage term only keeps the FSM from sticking.
                    if (write_done || !mem_we_reg) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Directed, self-checking bench for instr_encoder. Expected words are
// hand-encoded RV32 instructions.
// -----------------------------------------------------------------------------
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam logic [15:0] MAXC = 16'd5;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] base_addr;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [11:0] req_imm;
    logic        req_last;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] count;

    instr_encoder #(.MAX_COUNT(MAXC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .req_last   (req_last),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after posedge, so at negedge everything is settled
    // and reflects what the next posedge will see.
    always @(negedge clk) begin
        if (reset_n && mem_we && mem_ready) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
            $display("[%0t] write addr=%h data=%h", $time, mem_addr, mem_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic chk_write(input string tag, input int idx,
                             input logic [31:0] exp_a, input logic [31:0] exp_d);
        if (idx < wa.size()) begin
            chk({tag, "_addr"}, wa[idx], exp_a);
            chk({tag, "_data"}, wd[idx], exp_d);
        end else begin
            chk({tag, "_missing"}, 32'(wa.size()), 32'(idx + 1));
        end
    endtask

    task automatic do_start(input logic [31:0] base);
        clear_log();
        base_addr = base;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        $display("[%0t] start base=%h", $time, base);
    endtask

    // Holds the request until it is accepted; returns just after the
    // accepting edge so a following send() is back-to-back.
    task automatic send(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [11:0] imm, input logic last);
        bit ok;
        ok         = 1'b0;
        req_valid  = 1'b1;
        req_opcode = op;
        req_funct3 = f3;
        req_funct7 = f7;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
        req_last   = last;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) tick();
        req_valid = 1'b0;
        req_last  = 1'b0;
        $display("[%0t] req %s op=%h f3=%0d last=%0d accepted=%0d", $time, tag, op, f3, last, ok);
        chk({tag, "_accept"}, 32'(ok), 32'd1);
    endtask

    // Waits (bounded) for done, checks the pulse and the DONE-state outputs.
    task automatic finish_load(input string tag, input logic [15:0] exp_count);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'(exp_count));
        tick();
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b1;
        start      = 1'b0;
        base_addr  = 32'h0;
        req_valid  = 1'b0;
        req_opcode = 7'h0;
        req_funct3 = 3'h0;
        req_funct7 = 7'h0;
        req_rd     = 5'h0;
        req_rs1    = 5'h0;
        req_rs2    = 5'h0;
        req_imm    = 12'h0;
        req_last   = 1'b0;
        mem_ready  = 1'b1;

        // ---- reset state ----
        #2 reset_n = 1'b0;
        tick();
        tick();
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---- req_valid in IDLE has no effect ----
        req_valid  = 1'b1;
        req_opcode = R_TYPE;
        tick();
        tick();
        chk("idle_req_ready", 32'(req_ready), 32'd0);
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        chk("idle_count", 32'(count), 32'd0);
        req_valid = 1'b0;

        // ---- single ADD x3,x1,x2 ----
        do_start(32'h0000_0100);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_req_ready", 32'(req_ready), 32'd1);
        send("t1_add", R_TYPE, ADD_OR_SUB, 7'h00, 5'd3, 5'd1, 5'd2, 12'h0, 1'b1);
        chk("t1_lat1_we", 32'(mem_we), 32'd1);
        chk("t1_lat1_data", mem_wdata, 32'h002081B3);
        finish_load("t1", 16'd1);
        chk("t1_nwrites", 32'(wa.size()), 32'd1);
        chk_write("t1_w0", 0, 32'h100, 32'h002081B3);
        chk("t1_idle_count", 32'(count), 32'd1);

        // ---- back-to-back SUB / ADDI / SRAI ----
        do_start(32'h0000_0200);
        send("t2_sub", R_TYPE, ADD_OR_SUB, 7'h20, 5'd5, 5'd6, 5'd7, 12'h0, 1'b0);
        send("t2_addi", I_TYPE, ADDI, 7'h00, 5'd1, 5'd0, 5'd0, 12'hFFF, 1'b0);
        send("t2_srai", I_TYPE, SRLI_OR_SRAI, 7'h00, 5'd2, 5'd2, 5'd0, 12'h403, 1'b1);
        finish_load("t2", 16'd3);
        chk("t2_nwrites", 32'(wa.size()), 32'd3);
        chk_write("t2_w0", 0, 32'h200, 32'h407302B3);
        chk_write("t2_w1", 1, 32'h204, 32'hFFF00093);
        chk_write("t2_w2", 2, 32'h208, 32'h40315113);
        if (wc.size() == 3) begin
            chk("t2_gap01", 32'(wc[1] - wc[0]), 32'd1);
            chk("t2_gap12", 32'(wc[2] - wc[1]), 32'd1);
        end else begin
            chk("t2_gap_count", 32'(wc.size()), 32'd3);
        end
        chk("t2_err", 32'(err), 32'd0);

        // ---- backpressure: mem_ready low 3 cycles ----
        do_start(32'h0000_0303);
        chk("t3_base_align", mem_addr, 32'h300);
        mem_ready = 1'b0;
        send("t3_add", R_TYPE, ADD_OR_SUB, 7'h00, 5'd3, 5'd1, 5'd2, 12'h0, 1'b0);
        req_valid  = 1'b1;
        req_opcode = I_TYPE;
        req_funct3 = ADDI;
        req_rd     = 5'd6;
        req_rs1    = 5'd0;
        req_imm    = 12'h006;
        req_last   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_we", 32'(mem_we), 32'd1);
            chk("t3_stall_addr", mem_addr, 32'h300);
            chk("t3_stall_data", mem_wdata, 32'h002081B3);
            chk("t3_stall_ready", 32'(req_ready), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        send("t3_addi", I_TYPE, ADDI, 7'h00, 5'd6, 5'd0, 5'd0, 12'h006, 1'b1);
        finish_load("t3", 16'd2);
        chk("t3_nwrites", 32'(wa.size()), 32'd2);
        chk_write("t3_w0", 0, 32'h300, 32'h002081B3);
        chk_write("t3_w1", 1, 32'h304, 32'h00600313);

        // ---- illegal requests become NOP and set err ----
        do_start(32'h0000_0400);
        send("t4_xor_f7", R_TYPE, XOR, 7'h20, 5'd1, 5'd2, 5'd3, 12'h0, 1'b0);
        chk("t4_err_set", 32'(err), 32'd1);
        send("t4_slli_bad", I_TYPE, SLLI, 7'h00, 5'd1, 5'd1, 5'd0, 12'h421, 1'b0);
        send("t4_bad_op", 7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 12'h123, 1'b1);
        finish_load("t4", 16'd3);
        chk_write("t4_w0", 0, 32'h400, NOP);
        chk_write("t4_w1", 1, 32'h404, NOP);
        chk_write("t4_w2", 2, 32'h408, NOP);
        chk("t4_err_sticky", 32'(err), 32'd1);

        // ---- address wrap, start ignored while busy ----
        do_start(32'hFFFF_FFFE);
        chk("t5_err_cleared", 32'(err), 32'd0);
        send("t5_ori", I_TYPE, ORI, 7'h00, 5'd4, 5'd4, 5'd0, 12'h0F0, 1'b0);
        base_addr = 32'h0000_0500;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("t5_start_ignored_busy", 32'(busy), 32'd1);
        chk("t5_wrap_addr", mem_addr, 32'h0);
        send("t5_sll", R_TYPE, SLL, 7'h00, 5'd1, 5'd2, 5'd3, 12'h0, 1'b1);
        finish_load("t5", 16'd2);
        chk_write("t5_w0", 0, 32'hFFFF_FFFC, 32'h0F026213);
        chk_write("t5_w1", 1, 32'h0000_0000, 32'h003110B3);

        // ---- count saturation (MAX_COUNT = 5, six words) ----
        do_start(32'h0000_0700);
        for (int i = 1; i <= 6; i++) begin
            send("t6_addi", I_TYPE, ADDI, 7'h00, 5'(i), 5'd0, 5'd0, 12'(i), (i == 6));
        end
        finish_load("t6", MAXC);
        chk("t6_nwrites", 32'(wa.size()), 32'd6);
        chk_write("t6_w5", 5, 32'h714, 32'h00600313);

        // ---- reset mid-load while a write is pending ----
        do_start(32'h0000_0800);
        mem_ready = 1'b0;
        send("t7_add", R_TYPE, ADD_OR_SUB, 7'h00, 5'd3, 5'd1, 5'd2, 12'h0, 1'b0);
        chk("t7_pre_we", 32'(mem_we), 32'd1);
        begin
            int dc;
            dc = done_cnt;
            #2 reset_n = 1'b0;
            #1;
            chk("t7_rst_we", 32'(mem_we), 32'd0);
            chk("t7_rst_busy", 32'(busy), 32'd0);
            chk("t7_rst_addr", mem_addr, 32'h0);
            chk("t7_rst_wdata", mem_wdata, 32'h0);
            chk("t7_rst_count", 32'(count), 32'd0);
            chk("t7_rst_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            reset_n   = 1'b1;
            mem_ready = 1'b1;
            for (int i = 0; i < 5; i++) tick();
            chk("t7_no_done", 32'(done_cnt), 32'(dc));
            chk("t7_post_we", 32'(mem_we), 32'd0);
            chk("t7_post_busy", 32'(busy), 32'd0);
            chk("t7_post_nwrites", 32'(wa.size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter MAX_COUNT, default 16'hFFFF; saturation value of the instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin a program load at base_addr; honoured only in IDLE.
REQ-005 base_addr  input  32  byte address of the first word; bits[1:0] are ignored and forced to 0.
REQ-006 req_valid / req_ready  input / output  1 / 1  field-request handshake; a transfer occurs when both are high on a rising edge.
REQ-007 req_opcode  input  7  OpCode; only I_TYPE and R_TYPE are legal.
REQ-008 req_funct3 (3), req_funct7 (7), req_rd (5), req_rs1 (5), req_rs2 (5), req_imm (12)  inputs  instruction fields.
REQ-009 req_last  input  1  marks the final request of the program.
REQ-010 mem_we  output  1  write valid toward instruction memory.
REQ-011 mem_ready  input  1  memory accepts the write when high with mem_we.
REQ-012 mem_addr / mem_wdata  outputs  32 / 32  write address and encoded instruction word.
REQ-013 busy  output  1  high in RUN and DRAIN.
REQ-014 done  output  1  one-cycle pulse at the end of a load.
REQ-015 err  output  1  sticky illegal-request flag; cleared on start.
REQ-016 count  output  16  words written since the last start, saturating at MAX_COUNT.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start; this loads the address register with base_addr and clears count and err.
- RUN -> DRAIN on acceptance of a request with req_last=1.
- DRAIN -> DONE when the final memory write completes.
- DONE -> IDLE unconditionally after one cycle.
REQ-018 req_ready = (state==RUN) && (!mem_we || mem_ready); it is low in IDLE, DRAIN and DONE.
REQ-019 Output register stage:
- An accepted request is encoded and presented on mem_we/mem_addr/mem_wdata the following cycle (latency 1).
- The stage holds stable until mem_ready.
- Back-to-back acceptance sustains one word per cycle with mem_ready high.
REQ-020 Encoding:
- R_TYPE word = {funct7, rs2, rs1, funct3, rd, opcode}.
- I_TYPE word = {imm, rs1, funct3, rd, opcode}.
REQ-021 I-type shifts (funct3 SLLI or SRLI_OR_SRAI): imm[11:5] must be 7'h00, or 7'h20 with SRLI_OR_SRAI only; shamt = imm[4:0].
REQ-022 R_TYPE legality: funct7 must be 7'h00, or 7'h20 with ADD_OR_SUB or SRL_OR_SRA only.
REQ-023 An illegal request (bad opcode or REQ-021/022 violation):
- is still accepted and still consumes an address;
- is written as NOP 32'h00000013;
- sets err.
REQ-024 mem_addr increments by 4 after each completed write; it wraps modulo 2^32.
REQ-025 count increments on each completed write and holds at MAX_COUNT.
REQ-026 done is asserted only in DONE; busy is low in IDLE and DONE.
REQ-027 start is ignored outside IDLE.
REQ-028 req_valid outside RUN has no effect.
REQ-029 Simultaneous mem_ready completion and new acceptance in the same cycle load the new word with no bubble.

Reset
REQ-030 reset_n low at any time, including mid-load:
- forces IDLE;
- clears mem_we, done, busy and err;
- clears count, mem_addr and mem_wdata to 0;
- discards any pending word.
REQ-031 Reset deassertion produces no output activity until the next start.

Structure
REQ-032 The following are shared package content: OpCode, RTypeFunct3, ITypeFunct3, r_type_t, i_type_t, instruction_t, the FSM state enum, and NOP constant 32'h00000013.
REQ-033 A combinational sub-module instr_pack (fields in -> 32-bit word plus illegal flag) is instantiated once; the FSM, address and count logic stay in instr_encoder.

Verification
REQ-034 start with base_addr 32'h100, then one R request ADD x3,x1,x2 with last -> one write of 32'h002081B3 at 32'h100; done pulses; count=1.
REQ-035 Back-to-back requests SUB x5,x6,x7, ADDI x1,x0,-1, SRAI x2,x2,3 (last), mem_ready always high -> writes 32'h407302B3, 32'hFFF00093, 32'h40315113 at consecutive addresses, one per cycle.
REQ-036 mem_ready held low 3 cycles during a write -> mem_wdata/mem_addr stable, req_ready low, no request lost; count is correct after release.
REQ-037 R request with funct7 7'h20 and funct3 XOR -> 32'h00000013 written; err high until the next start.
REQ-038 Load with base_addr 32'hFFFFFFFC and two words -> second write at 32'h00000000.
REQ-039 reset_n asserted while mem_we is high in RUN -> mem_we and busy drop immediately; state IDLE; no done pulse.
